obi_mem_responder: RTL and testbench

- Memory-side responder for the core's instruction/data bus (req/gnt/rvalid handshake) in the compliance simulation top.
- Grants requests and performs byte-enabled writes and word reads on an internal word array.
- Returns responses after a fixed, parameterised latency, with programmable stall and error injection for protocol stress.
- One instance serves the instruction port (writes tied off); a second serves the data port.

---
 rtl/obi_mem_responder.sv | 110 +++++++++++
 tb/tb_obi_mem_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_mem_responder.sv
// Memory-side responder for a req/gnt/rvalid bus: byte-enabled word array,
// fixed-latency in-order response pipeline, address-window error injection.
module obi_mem_responder #(
    parameter int unsigned MemWords       = 16384,
    parameter int unsigned Latency        = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] ErrAddrBase    = 32'hFFFF_FFF0,
    parameter logic [31:0] ErrAddrLimit   = 32'hFFFF_FFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [2:0]  outstanding_o
);
    localparam int unsigned IdxW     = $clog2(MemWords);
    localparam logic [32:0] MemBytes = 33'(MemWords) << 2;
    localparam logic [2:0]  MaxOut   = 3'(MaxOutstanding);
    localparam logic [31:0] ErrSpan  = ErrAddrLimit - ErrAddrBase;

    logic [31:0]     mem_q [MemWords];
    logic [IdxW-1:0] idx;
    logic            addr_err;
    logic            accept;
    logic [31:0]     rd_word;

    logic            vld_q   [Latency];
    logic [31:0]     rdata_q [Latency];
    logic            err_q   [Latency];
    logic [2:0]      outstanding_q, outstanding_d;

    assign idx = addr_i[IdxW+1:2];
    // Unsigned window test: addresses below the base wrap to large offsets.
    assign addr_err = ((addr_i - ErrAddrBase) <= ErrSpan) || ({1'b0, addr_i} >= MemBytes);

    assign gnt_o   = req_i & ~stall_i & (outstanding_q < MaxOut);
    assign accept  = req_i & gnt_o & RST_N;
    assign rd_word = (we_i | addr_err) ? '0 : mem_q[idx];

    always_ff @(posedge CLK) begin
        if (accept && we_i && !addr_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        if (accept && !rvalid_o) begin
            outstanding_d = outstanding_q + 3'd1;
        end else if (!accept && rvalid_o) begin
            outstanding_d = outstanding_q - 3'd1;
        end
    end

    // Slot 0 captures the response at the acceptance edge; the last slot drives the bus.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < int'(Latency); i++) begin
                vld_q[i]   <= 1'b0;
                rdata_q[i] <= '0;
                err_q[i]   <= 1'b0;
            end
            outstanding_q <= '0;
        end else begin
            vld_q[0]   <= accept;
            rdata_q[0] <= accept ? rd_word : '0;
            err_q[0]   <= accept & addr_err;
            for (int i = 1; i < int'(Latency); i++) begin
                vld_q[i]   <= vld_q[i-1];
                rdata_q[i] <= rdata_q[i-1];
                err_q[i]   <= err_q[i-1];
            end
            outstanding_q <= outstanding_d;
        end
    end

    assign rvalid_o      = vld_q[Latency-1];
    assign rdata_o       = rdata_q[Latency-1];
    assign err_o         = err_q[Latency-1];
    assign outstanding_o = outstanding_q;

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (MemWords >= 2 && (MemWords & (MemWords - 1)) == 0)
                else $error("MemWords must be a power of two >= 2");
            assert (Latency >= 1 && Latency <= 4)
                else $error("Latency must be 1..4");
            assert (MaxOutstanding >= 1 && MaxOutstanding <= Latency + 1)
                else $error("MaxOutstanding must be 1..Latency+1");
            assert (ErrAddrLimit >= ErrAddrBase)
                else $error("error window limit below base");
            assert (!(rvalid_o && outstanding_q == 3'd0))
                else $error("rvalid with nothing outstanding");
            assert (outstanding_q <= MaxOut)
                else $error("outstanding count above maximum");
        end
    end
endmodule

// File: tb/tb_obi_mem_responder.sv
// Bench for obi_mem_responder: a Latency=1 and a Latency=3 instance, directed
// scenarios plus random traffic scored against a queue-based reference model.
module tb_obi_mem_responder;
    localparam int          LAT0     = 1;
    localparam int          LAT1     = 3;
    localparam int          MAXO     = 2;
    localparam logic [31:0] ERR_BASE = 32'hFFFF_FFF0;
    localparam logic [31:0] ERR_LIM  = 32'hFFFF_FFFF;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  req, gnt, rvalid, err;
    logic        we, stall;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic [31:0] rdata [2];
    logic [2:0]  outst [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit live   = 0;
    int pk [2] = '{0, 0};

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       rq [2][$];
    logic [31:0] mm [int unsigned];

    obi_mem_responder #(.MemWords(16384), .Latency(LAT0), .MaxOutstanding(MAXO),
                        .ErrAddrBase(ERR_BASE), .ErrAddrLimit(ERR_LIM)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .req_i(req[0]), .gnt_o(gnt[0]), .we_i(we),
        .be_i(be), .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
        .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
        .outstanding_o(outst[0])
    );

    obi_mem_responder #(.MemWords(16384), .Latency(LAT1), .MaxOutstanding(MAXO),
                        .ErrAddrBase(ERR_BASE), .ErrAddrLimit(ERR_LIM)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .req_i(req[1]), .gnt_o(gnt[1]), .we_i(we),
        .be_i(be), .addr_i(addr), .wdata_i(wdata), .stall_i(stall),
        .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
        .outstanding_o(outst[1])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    function automatic string tg(input int d, input string s);
        return $sformatf("dut%0d_%s", d, s);
    endfunction

    function automatic logic [31:0] pool(input int i);
        if (i == 14) return 32'h0000_0000;
        if (i == 15) return 32'h0000_FFFC;
        return 32'h0000_0400 + 32'(i) * 32'd4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: an accepted request becomes a queued response due Latency cycles later.
    task automatic model_accept(input int d);
        resp_t       r;
        longint      a;
        logic        e;
        int unsigned key;
        logic [31:0] w;
        a   = longint'(addr);
        e   = (a >= longint'(ERR_BASE) && a <= longint'(ERR_LIM)) || (a >= 64'd65536);
        key = 32'(d) * 32'h0001_0000 + 32'(addr[15:2]);
        r.due = cyc + lat_of(d);
        r.err = e;
        r.data = 32'h0;
        if (we) begin
            if (!e) begin
                w = mm[key];
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
                end
                mm[key] = w;
            end
        end else if (!e) begin
            r.data = mm[key];
        end
        rq[d].push_back(r);
    endtask

    task automatic mon(input int d);
        int    n;
        bit    ev, eg;
        resp_t r;
        n = rq[d].size();
        if (live) begin
            if (int'(outst[d]) > pk[d]) pk[d] = int'(outst[d]);
            chk(tg(d, "outstanding"), 32'(outst[d]), 32'(n));
            ev = (n > 0) && (rq[d][0].due == cyc);
            chk(tg(d, "rvalid"), 32'(rvalid[d]), 32'(ev));
            if (ev) begin
                r = rq[d].pop_front();
                chk(tg(d, "rdata"), rdata[d], r.data);
                chk(tg(d, "err"), 32'(err[d]), 32'(r.err));
            end else begin
                chk(tg(d, "rdata_idle"), rdata[d], 32'h0);
                chk(tg(d, "err_idle"), 32'(err[d]), 32'h0);
            end
        end
        eg = req[d] && !stall && (n < MAXO);
        if (live && RST_N) chk(tg(d, "gnt"), 32'(gnt[d]), 32'(eg));
        if (!RST_N) rq[d].delete();
        else if (live && eg) model_accept(d);
    endtask

    always @(negedge CLK) begin
        cyc++;
        for (int d = 0; d < 2; d++) mon(d);
        if (!RST_N) live = 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #2;
        end
    endtask

    // Presents one request and holds it until granted; returns the number of refused cycles.
    task automatic drive(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] wd, input int stl, output int waits);
        bit got;
        got   = 0;
        waits = 0;
        req[d] = 1'b1; we = w; be = b; addr = a; wdata = wd; stall = (stl > 0);
        for (int n = 0; n < 64; n++) begin
            @(negedge CLK);
            #1;
            if (gnt[d]) begin
                got   = 1;
                waits = n;
                break;
            end
            @(posedge CLK);
            #2;
            stall = (n + 1 < stl);
        end
        if (got) begin
            @(posedge CLK);
            #2;
        end
        req[d] = 1'b0;
        stall  = 1'b0;
        if (!got) chk(tg(d, "grant_timeout"), 32'(got), 32'h1);
    endtask

    task automatic expect_resp(input int d, input logic [31:0] dat, input logic e);
        repeat (lat_of(d) - 1) begin
            @(posedge CLK);
            #2;
        end
        @(negedge CLK);
        #1;
        chk(tg(d, "dir_rvalid"), 32'(rvalid[d]), 32'h1);
        chk(tg(d, "dir_rdata"), rdata[d], dat);
        chk(tg(d, "dir_err"), 32'(err[d]), 32'(e));
        @(posedge CLK);
        #2;
    endtask

    initial begin
        int          w;
        int          w3 [4];
        int          sel;
        logic [31:0] a;

        RST_N = 1'b0; req = '0; we = 1'b0; be = '0; addr = '0; wdata = '0; stall = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b1;

        // Reset state
        @(negedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk(tg(d, "rst_outstanding"), 32'(outst[d]), 32'h0);
            chk(tg(d, "rst_rvalid"), 32'(rvalid[d]), 32'h0);
            chk(tg(d, "rst_rdata"), rdata[d], 32'h0);
            chk(tg(d, "rst_err"), 32'(err[d]), 32'h0);
        end
        @(posedge CLK);
        #2;

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) drive(d, 1'b1, 4'hF, pool(i), $urandom, 0, w);
            idle(5);
        end

        // Single write then read, Latency=1
        drive(0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 0, w);
        chk("t1_write_wait", 32'(w), 32'h0);
        expect_resp(0, 32'h0, 1'b0);
        drive(0, 1'b0, 4'hF, 32'h100, 32'h0, 0, w);
        chk("t1_read_wait", 32'(w), 32'h0);
        expect_resp(0, 32'hDEAD_BEEF, 1'b0);

        // Byte-enabled merge
        drive(0, 1'b1, 4'hF, 32'h200, 32'h1122_3344, 0, w);
        expect_resp(0, 32'h0, 1'b0);
        drive(0, 1'b1, 4'b0101, 32'h200, 32'hAABB_CCDD, 0, w);
        expect_resp(0, 32'h0, 1'b0);
        drive(0, 1'b0, 4'hF, 32'h200, 32'h0, 0, w);
        expect_resp(0, 32'h11BB_33DD, 1'b0);

        // Pipelined reads against the outstanding limit, Latency=3
        for (int i = 0; i < 4; i++) drive(1, 1'b0, 4'hF, pool(i), 32'h0, 0, w3[i]);
        chk("t3_first_wait", 32'(w3[0]), 32'h0);
        chk("t3_second_wait", 32'(w3[1]), 32'h0);
        chk("t3_third_held", 32'(w3[2] > 0), 32'h1);
        idle(6);
        chk("t3_peak_outstanding", 32'(pk[1]), 32'h2);

        // Error window and out-of-range addresses
        drive(0, 1'b1, 4'hF, 32'h0000_FFF4, 32'h5A5A_0FF4, 0, w);
        expect_resp(0, 32'h0, 1'b0);
        drive(0, 1'b1, 4'hF, 32'hFFFF_FFF4, 32'h1234_5678, 0, w);
        expect_resp(0, 32'h0, 1'b1);
        drive(0, 1'b0, 4'hF, 32'hFFFF_FFF4, 32'h0, 0, w);
        expect_resp(0, 32'h0, 1'b1);
        drive(0, 1'b0, 4'hF, 32'h0000_FFF4, 32'h0, 0, w);
        expect_resp(0, 32'h5A5A_0FF4, 1'b0);
        drive(0, 1'b0, 4'hF, 32'h0001_0000, 32'h0, 0, w);
        expect_resp(0, 32'h0, 1'b1);

        // Stall while a response is in flight
        drive(1, 1'b0, 4'hF, pool(5), 32'h0, 0, w);
        req[1] = 1'b1; we = 1'b0; be = 4'hF; addr = pool(6); stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            #1;
            chk("t5_stalled_gnt", 32'(gnt[1]), 32'h0);
            @(posedge CLK);
            #2;
        end
        stall = 1'b0;
        @(negedge CLK);
        #1;
        chk("t5_released_gnt", 32'(gnt[1]), 32'h1);
        @(posedge CLK);
        #2;
        req[1] = 1'b0;
        idle(6);

        // Reset with a read in flight and a write presented during reset
        drive(1, 1'b1, 4'hF, 32'h300, 32'hC0FF_EE01, 0, w);
        idle(4);
        drive(1, 1'b0, 4'hF, 32'h300, 32'h0, 0, w);
        RST_N = 1'b0;
        req[1] = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h300; wdata = 32'h3F00_11FE;
        @(posedge CLK);
        #2;
        RST_N = 1'b1;
        req[1] = 1'b0;
        @(negedge CLK);
        #1;
        chk("t6_outstanding_after_rst", 32'(outst[1]), 32'h0);
        chk("t6_rvalid_after_rst", 32'(rvalid[1]), 32'h0);
        @(posedge CLK);
        #2;
        idle(5);
        drive(1, 1'b0, 4'hF, 32'h300, 32'h0, 0, w);
        expect_resp(1, 32'hC0FF_EE01, 1'b0);

        // Random traffic against the reference model
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) begin
                sel = int'($urandom_range(0, 9));
                if (sel == 0) a = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                else if (sel == 1) a = 32'h0001_0000 + ($urandom & 32'h00FF_FFFC);
                else a = pool(int'($urandom_range(0, 15))) | ($urandom & 32'h3);
                drive(d, 1'($urandom), 4'($urandom), a, $urandom,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, w);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            idle(6);
        end

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
